distance_zone_indicator: RTL and testbench

//  Maps ultrasonic echo-width samples (clk cycles) to one of NZONES distance zones and drives one

---
 rtl/distance_zone_indicator_pkg.sv | 19 +
 rtl/distance_zone_indicator_if.sv | 35 +++
 rtl/distance_zone_indicator_classify.sv | 53 +++++
 rtl/distance_zone_indicator.sv | 137 +++++++++++++
 tb/tb_distance_zone_indicator.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/distance_zone_indicator_pkg.sv
// rtl/distance_zone_indicator_pkg.sv - shared constants and helpers for the ultrasonic zone indicator
package ultrasonido_pkg;

  localparam int DEF_CNT_W  = 20;
  localparam int DEF_NZONES = 3;

  // Zone bounds, farthest first: zone i lies strictly between B[i+1] and B[i]
  localparam logic [(DEF_NZONES+1)*DEF_CNT_W-1:0] DEF_BOUNDS =
    {20'd70000, 20'd50000, 20'd30000, 20'd3000};

  // Committed-zone code meaning "no zone lit"
  localparam int ZONE_NONE = 0;

  // Width of a zone code able to hold 0 (none) .. nzones
  function automatic int zone_w(input int nzones);
    return $clog2(nzones + 1);
  endfunction

endpackage

// File: rtl/distance_zone_indicator_if.sv
// rtl/distance_zone_indicator_if.sv - sample input and zone/LED output bundle
interface distance_zone_indicator_if
  import ultrasonido_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NZONES = DEF_NZONES
);

  localparam int ZW = zone_w(NZONES);

  logic              sample_valid;
  logic [CNT_W-1:0]  sample;
  logic [NZONES-1:0] led_n;
  logic [ZW-1:0]     zone;
  logic              stale;

  // Echo-width source side
  modport master (
    output sample_valid,
    output sample,
    input  led_n,
    input  zone,
    input  stale
  );

  // Indicator side
  modport slave (
    input  sample_valid,
    input  sample,
    output led_n,
    output zone,
    output stale
  );

endinterface

// File: rtl/distance_zone_indicator_classify.sv
// rtl/distance_zone_indicator_classify.sv - combinational sample-to-zone classifier with hysteresis
module dzi_zone_classify
  import ultrasonido_pkg::*;
#(
  parameter int                            CNT_W  = DEF_CNT_W,
  parameter int                            NZONES = DEF_NZONES,
  parameter logic [(NZONES+1)*CNT_W-1:0]   BOUNDS = DEF_BOUNDS,
  parameter int                            HYST   = 1000,
  localparam int                           ZW     = zone_w(NZONES)
) (
  input  logic [CNT_W-1:0] sample,
  input  logic [ZW-1:0]    zone,
  output logic [ZW-1:0]    cls
);

  // Computed one bit wider so the hysteresis window can saturate instead of wrapping
  localparam logic [CNT_W:0] MAXV  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] HYSTW = (CNT_W+1)'(HYST);

  // B[0] sits in the most significant slot of the packed bound vector
  function automatic logic [CNT_W-1:0] bnd(input int i);
    return BOUNDS[(NZONES-i)*CNT_W +: CNT_W];
  endfunction

  logic [CNT_W:0] lo;
  logic [CNT_W:0] hi;
  logic [CNT_W:0] s_w;

  assign s_w = {1'b0, sample};

  // Raw strict-interval class, then the committed zone widens its own window by HYST
  always_comb begin
    cls = ZW'(ZONE_NONE);
    lo  = '0;
    hi  = '0;
    // Descending scan so the lowest matching zone index is the one that sticks
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (sample > bnd(i + 1) && sample < bnd(i)) begin
        cls = ZW'(i + 1);
      end
    end
    for (int k = 1; k <= NZONES; k++) begin
      if (zone == ZW'(k)) begin
        lo = ({1'b0, bnd(k)} > HYSTW) ? ({1'b0, bnd(k)} - HYSTW) : '0;
        hi = ({1'b0, bnd(k - 1)} + HYSTW > MAXV) ? MAXV : ({1'b0, bnd(k - 1)} + HYSTW);
        if (s_w > lo && s_w < hi) begin
          cls = ZW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/distance_zone_indicator.sv
// rtl/distance_zone_indicator.sv - echo width to zone LEDs with confirmation and stale timeout (optional DZI_BLINK_EN nearest-zone blink)
module distance_zone_indicator
  import ultrasonido_pkg::*;
#(
  parameter int                          CNT_W     = DEF_CNT_W,
  parameter int                          NZONES    = DEF_NZONES,
  parameter logic [(NZONES+1)*CNT_W-1:0] BOUNDS    = DEF_BOUNDS,
  parameter int                          HYST      = 1000,
  parameter int                          CONFIRM   = 3,
  parameter int                          STALE_CYC = 5_000_000,
  parameter int                          BLINK_DIV = 12_500_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  distance_zone_indicator_if.slave bus
);

  localparam int ZW = zone_w(NZONES);
  localparam int CW = $clog2(CONFIRM + 1);
  localparam int SW = $clog2(STALE_CYC + 1);

  logic [ZW-1:0]     cls;
  logic [ZW-1:0]     zone_q,  zone_d;
  logic [ZW-1:0]     cand_q,  cand_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [SW-1:0]     scnt_q,  scnt_d;
  logic              stale_q, stale_d;
  logic [NZONES-1:0] led_q,   led_d;

`ifdef DZI_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q,  bph_d;
`endif

  dzi_zone_classify #(
    .CNT_W  (CNT_W),
    .NZONES (NZONES),
    .BOUNDS (BOUNDS),
    .HYST   (HYST)
  ) u_classify (
    .sample (bus.sample),
    .zone   (zone_q),
    .cls    (cls)
  );

  // Next-state: confirmation on each strobe, idle counting toward stale otherwise, LED decode
  always_comb begin
    zone_d  = zone_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    stale_d = stale_q;
    if (bus.sample_valid) begin
      // A strobe always beats an expiring idle counter
      scnt_d  = '0;
      stale_d = 1'b0;
      if (cls == cand_q) begin
        cnt_d = (cnt_q >= CW'(CONFIRM)) ? CW'(CONFIRM) : cnt_q + 1'b1;
      end else begin
        cand_d = cls;
        cnt_d  = CW'(1);
      end
      if (cnt_d == CW'(CONFIRM) && cand_d != zone_q) begin
        zone_d = cand_d;
      end
    end else if (scnt_q < SW'(STALE_CYC)) begin
      scnt_d = scnt_q + 1'b1;
      if (scnt_d == SW'(STALE_CYC)) begin
        stale_d = 1'b1;
        zone_d  = ZW'(ZONE_NONE);
        cnt_d   = '0;
      end
    end

`ifdef DZI_BLINK_EN
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    if (zone_d != zone_q) begin
      // Every zone entry restarts the blink with the LED lit
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else if (zone_q == ZW'(NZONES)) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
`endif

    led_d = '1;
    for (int i = 0; i < NZONES; i++) begin
      if (zone_d == ZW'(i + 1)) begin
        led_d[i] = 1'b0;
      end
    end
`ifdef DZI_BLINK_EN
    if (zone_d == ZW'(NZONES) && bph_d) begin
      led_d[NZONES-1] = 1'b1;
    end
`endif
  end

  // State registers; reset discards any partially confirmed candidate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zone_q  <= ZW'(ZONE_NONE);
      cand_q  <= ZW'(ZONE_NONE);
      cnt_q   <= '0;
      scnt_q  <= '0;
      stale_q <= 1'b0;
      led_q   <= '1;
`ifdef DZI_BLINK_EN
      bcnt_q  <= '0;
      bph_q   <= 1'b0;
`endif
    end else begin
      zone_q  <= zone_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      stale_q <= stale_d;
      led_q   <= led_d;
`ifdef DZI_BLINK_EN
      bcnt_q  <= bcnt_d;
      bph_q   <= bph_d;
`endif
    end
  end

  assign bus.zone  = zone_q;
  assign bus.led_n = led_q;
  assign bus.stale = stale_q;

endmodule

// File: tb/tb_distance_zone_indicator.sv
// tb/tb_distance_zone_indicator.sv - randomized self-checking bench for distance_zone_indicator
module tb_distance_zone_indicator;

  localparam int CNT_W     = 20;
  localparam int NZ        = 3;
  localparam int HYST      = 1000;
  localparam int CONFIRM   = 3;
  localparam int STALE_CYC = 40;
  localparam int MAXV      = (1 << CNT_W) - 1;

  int bnd [0:NZ] = '{70000, 50000, 30000, 3000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  distance_zone_indicator_if #(.CNT_W(CNT_W), .NZONES(NZ)) bus ();

  distance_zone_indicator #(
    .CNT_W     (CNT_W),
    .NZONES    (NZ),
    .HYST      (HYST),
    .CONFIRM   (CONFIRM),
    .STALE_CYC (STALE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int m_zone  = 0;
  int m_stale = 0;
  int m_idle  = 0;
  int hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_class(input int s, input int z);
    int c = 0;
    int lo, hi;
    for (int i = 0; i < NZ; i++) begin
      if (c == 0 && s > bnd[i+1] && s < bnd[i]) c = i + 1;
    end
    if (z > 0) begin
      lo = bnd[z] - HYST;
      if (lo < 0) lo = 0;
      hi = bnd[z-1] + HYST;
      if (hi > MAXV) hi = MAXV;
      if (s > lo && s < hi) c = z;
    end
    return c;
  endfunction

  function automatic int led_exp(input int z);
    return (z == 0) ? 7 : (7 & ~(1 << (z - 1)));
  endfunction

  task automatic model_step(input logic v, input int s);
    bit same;
    if (!rst_n) begin
      m_zone = 0; m_stale = 0; m_idle = 0; hist.delete();
    end else if (v) begin
      m_idle = 0;
      m_stale = 0;
      hist.push_back(model_class(s, m_zone));
      if (hist.size() > CONFIRM) void'(hist.pop_front());
      if (hist.size() == CONFIRM) begin
        same = 1;
        foreach (hist[k]) if (hist[k] != hist[0]) same = 0;
        if (same && hist[0] != m_zone) m_zone = hist[0];
      end
    end else if (m_idle < STALE_CYC) begin
      m_idle++;
      if (m_idle == STALE_CYC) begin
        m_stale = 1; m_zone = 0; hist.delete();
      end
    end
  endtask

  task automatic cycle(input logic v, input int s);
    bus.sample_valid = v;
    bus.sample = s[CNT_W-1:0];
    model_step(v, s);
    @(posedge clk);
    #1;
    check("zone", bus.zone, m_zone);
    check("led_n", bus.led_n, led_exp(m_zone));
    check("stale", bus.stale, m_stale);
  endtask

  task automatic strobes(input int s, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, s);
  endtask

  initial begin
    int s, j, off;
    int offs [0:8] = '{-1001, -1000, -999, -1, 0, 1, 999, 1000, 1001};
    bus.sample_valid = 1'b0;
    bus.sample = '0;

    // Reset with strobes held high
    rst_n = 1'b0;
    strobes(60000, 2);
    check("rst_zone", bus.zone, 0);
    check("rst_led", bus.led_n, 3'b111);
    check("rst_stale", bus.stale, 0);
    rst_n = 1'b1;

    // Three-sample confirmation into zone 1
    strobes(60000, 2);
    check("t2_two_strobes", bus.zone, 0);
    strobes(60000, 1);
    check("t2_zone", bus.zone, 1);
    check("t2_led", bus.led_n, 3'b110);

    // Hysteresis holds zone 1, deeper sample moves to zone 2
    strobes(49500, 5);
    check("t3_hold", bus.zone, 1);
    strobes(48000, 3);
    check("t3_zone", bus.zone, 2);
    check("t3_led", bus.led_n, 3'b101);

    // Glitchy pattern needs three consecutive 10000 samples
    strobes(40000, 1); strobes(10000, 1); strobes(40000, 1);
    strobes(10000, 2);
    check("t4_not_yet", bus.zone, 2);
    strobes(10000, 1);
    check("t4_zone", bus.zone, 3);

    // Stale at exactly STALE_CYC idle cycles
    for (int i = 0; i < STALE_CYC - 1; i++) cycle(1'b0, 0);
    check("t5_pre_stale", bus.stale, 0);
    cycle(1'b0, 0);
    check("t5_stale", bus.stale, 1);
    check("t5_zone", bus.zone, 0);
    check("t5_led", bus.led_n, 3'b111);
    strobes(10000, 1);
    check("t5_clear", bus.stale, 0);
    for (int i = 0; i < STALE_CYC - 1; i++) cycle(1'b0, 0);
    strobes(10000, 1);
    check("t5_expiry_strobe", bus.stale, 0);

    // Samples equal to a bound classify as none
    rst_n = 1'b0; cycle(1'b0, 0); rst_n = 1'b1;
    strobes(50000, 3);
    check("t6_b50000", bus.zone, 0);
    strobes(70000, 3);
    check("t6_b70000", bus.zone, 0);
    strobes(30000, 3);
    check("t6_b30000", bus.zone, 0);
    strobes(3000, 3);
    check("t6_b3000", bus.zone, 0);

    // Randomized traffic, with occasional long idle bursts and resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; cycle(1'b1, 60000); rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        for (int i = 0; i < STALE_CYC + $urandom_range(0, 3) - 2; i++) cycle(1'b0, 0);
      end else if ($urandom_range(0, 2) == 0) begin
        cycle(1'b0, 0);
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          j = $urandom_range(0, NZ);
          off = offs[$urandom_range(0, 8)];
          s = bnd[j] + off;
        end else begin
          s = $urandom_range(0, 80000);
        end
        // Bursts of repeats make commits frequent
        strobes(s, $urandom_range(1, 4));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
